// File: rtl/decode_stage_pipe.sv
// rtl/decode_stage_pipe.sv - registered MIPS decode stage with forwarding, interlock and ID/EX handshake
module decode_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int RBITS    = 5,
  parameter int RA_IDX   = 31,
  parameter int LINK_OFS = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic             imm_src,
  input  logic             sign_ext,
  input  logic [1:0]       reg_dest,
  input  logic             flush,
  output logic [RBITS-1:0] r1,
  output logic [RBITS-1:0] r2,
  input  logic [XLEN-1:0]  v1,
  input  logic [XLEN-1:0]  v2,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic [RBITS-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_val,
  input  logic             mem_wr,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [XLEN-1:0]  mem_val,
  output logic             eq_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RBITS-1:0] rd,
  output logic [RBITS-1:0] sht,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  vs,
  output logic [XLEN-1:0]  vt,
  output logic             eq,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             out_valid_q;
  logic [RBITS-1:0] rd_q, sht_q, rd_d;
  logic [XLEN-1:0]  imm_q, vs_q, vt_q, imm_d, vs_d, vt_d;
  logic             eq_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             hazard, adv;

  // EX result wins over MEM; a load in EX has no value yet so it never forwards.
  function automatic logic [XLEN-1:0] fwd(
    input logic [RBITS-1:0] r,
    input logic [XLEN-1:0]  rf,
    input logic             e_wr,
    input logic             e_ld,
    input logic [RBITS-1:0] e_rd,
    input logic [XLEN-1:0]  e_val,
    input logic             m_wr,
    input logic [RBITS-1:0] m_rd,
    input logic [XLEN-1:0]  m_val
  );
    if (r == '0)                             return '0;
    else if (e_wr && !e_ld && e_rd == r)     return e_val;
    else if (m_wr && m_rd == r)              return m_val;
    else                                     return rf;
  endfunction

  assign r1 = RBITS'(instr[25:21]);
  assign r2 = RBITS'(instr[20:16]);

  // Operand forwarding, immediate generation and destination select.
  always_comb begin
    vs_d = fwd(r1, v1, ex_wr, ex_load, ex_rd, ex_val, mem_wr, mem_rd, mem_val);
    vt_d = fwd(r2, v2, ex_wr, ex_load, ex_rd, ex_val, mem_wr, mem_rd, mem_val);
    if (imm_src)       imm_d = pc + XLEN'(LINK_OFS);
    else if (sign_ext) imm_d = {{(XLEN-16){instr[15]}}, instr[15:0]};
    else               imm_d = {{(XLEN-16){1'b0}}, instr[15:0]};
    case (reg_dest)
      2'b00:   rd_d = '0;
      2'b01:   rd_d = RBITS'(RA_IDX);
      2'b10:   rd_d = RBITS'(instr[15:11]);
      default: rd_d = RBITS'(instr[20:16]);
    endcase
  end

  assign eq_c     = (vs_d == vt_d);
  assign hazard   = in_valid && ex_wr && ex_load && (ex_rd != '0) &&
                    ((ex_rd == r1) || (ex_rd == r2));
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !hazard && !flush;

  // ID/EX pipeline register: flush beats load, bubbles on interlock, holds on backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rd_q        <= '0;
      sht_q       <= '0;
      imm_q       <= '0;
      vs_q        <= '0;
      vt_q        <= '0;
      eq_q        <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (adv) begin
      if (in_valid && !hazard) begin
        out_valid_q <= 1'b1;
        rd_q        <= rd_d;
        sht_q       <= RBITS'(instr[10:6]);
        imm_q       <= imm_d;
        vs_q        <= vs_d;
        vt_q        <= vt_d;
        eq_q        <= eq_c;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Saturating count of cycles lost to load-use interlock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (hazard && !flush && stall_cnt_q != '1)
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign out_valid = out_valid_q;
  assign rd        = rd_q;
  assign sht       = sht_q;
  assign imm       = imm_q;
  assign vs        = vs_q;
  assign vt        = vt_q;
  assign eq        = eq_q;
  assign stall_cnt = stall_cnt_q;

endmodule
